// File: rtl/pattern_adc_source.sv
// Synthetic ADC frame source: builds CHANNELS pattern samples per frame tick
// and streams them LSB byte first into the slot write FIFO when space allows.
module pattern_adc_source #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_BYTES = 3,
  parameter int unsigned CLK_DIV      = 256,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter logic [31:0] LFSR_SEED    = 32'h00000001
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      direction,
  input  logic [1:0]                mode,
  input  logic [8*SAMPLE_BYTES-1:0] pattern_word,
  output logic                      fifo_clk,
  output logic [7:0]                fifo_data,
  output logic                      fifo_write,
  input  logic [ADDR_WIDTH-1:0]     fifo_addr_in,
  input  logic [ADDR_WIDTH-1:0]     fifo_addr_out,
  output logic [31:0]               sample_count,
  output logic [15:0]               overflow_count,
  output logic                      busy
);
  localparam int unsigned SW = 8 * SAMPLE_BYTES;
  localparam int unsigned N  = CHANNELS * SAMPLE_BYTES;
  localparam int unsigned FW = CHANNELS * SW;
  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state, w_state_next;
  logic [TW-1:0]         r_tick_cnt;
  logic [FW-1:0]         r_shift;
  logic [BW-1:0]         r_byte_cnt;
  logic [SW-1:0]         r_ramp;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_sample_count;
  logic [15:0]           r_overflow_count;

  logic                  w_tick, w_room, w_last, w_capture, w_drop;
  logic [ADDR_WIDTH-1:0] w_used, w_free;
  logic [FW-1:0]         w_frame;
  logic [31:0]           w_lfsr_next;
  logic [31:0]           w_lfsr_walk;
  logic [SW-1:0]         w_sample;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign w_tick = (r_tick_cnt == TW'(CLK_DIV - 1));
  assign w_used = fifo_addr_in - fifo_addr_out;
  assign w_free = '1 - w_used;
  assign w_room = (32'(w_free) >= 32'(N));
  assign w_last = (r_byte_cnt == BW'(N - 1));

  // Channel c of the LFSR pattern is the state after c steps; the walk ends CHANNELS steps on.
  always_comb begin
    w_frame     = '0;
    w_sample    = '0;
    w_lfsr_walk = r_lfsr;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      case (mode)
        2'd0:    w_sample = pattern_word;
        2'd1:    w_sample = r_ramp + SW'(c);
        2'd2:    w_sample = w_lfsr_walk[SW-1:0];
        default: begin
          w_sample             = SW'(r_sample_count);
          w_sample[SW-1 -: 8]  = 8'(c);
        end
      endcase
      w_frame[c*SW +: SW] = w_sample;
      w_lfsr_walk         = lfsr_step(w_lfsr_walk);
    end
    w_lfsr_next = w_lfsr_walk;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && enable && direction) begin
          if (w_room) begin
            w_capture    = 1'b1;
            w_state_next = S_SEND;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (w_tick) w_drop = 1'b1;
        if (w_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt       <= '0;
      r_shift          <= '0;
      r_byte_cnt       <= '0;
      r_ramp           <= '0;
      r_lfsr           <= LFSR_SEED;
      r_sample_count   <= '0;
      r_overflow_count <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_drop && (r_overflow_count != '1))
        r_overflow_count <= r_overflow_count + 16'd1;
      if (w_capture) begin
        r_shift    <= w_frame;
        r_byte_cnt <= '0;
        if (mode == 2'd1) r_ramp <= r_ramp + SW'(1);
        if (mode == 2'd2) r_lfsr <= w_lfsr_next;
      end else if (r_state == S_SEND) begin
        r_shift    <= r_shift >> 8;
        r_byte_cnt <= r_byte_cnt + BW'(1);
        if (w_last) r_sample_count <= r_sample_count + 32'd1;
      end
    end
  end

  assign fifo_clk       = clk;
  assign fifo_write     = (r_state == S_SEND);
  assign fifo_data      = fifo_write ? r_shift[7:0] : '0;
  assign busy           = fifo_write;
  assign sample_count   = r_sample_count;
  assign overflow_count = r_overflow_count;
endmodule

// File: tb/tb_pattern_adc_source.sv
// Bench for pattern_adc_source: directed vector table, hand-written mid-frame
// enable-drop and reset sequences, then random windows against a pattern model.
module tb_pattern_adc_source;
  localparam int unsigned CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, direction = 1'b0;
  logic [1:0]  mode = '0;
  logic [23:0] pattern_word = '0;
  logic        fifo_clk;
  logic [7:0]  fifo_data;
  logic        fifo_write;
  logic [10:0] fifo_addr_in = '0, fifo_addr_out = '0;
  logic [31:0] sample_count;
  logic [15:0] overflow_count;
  logic        busy;

  pattern_adc_source #(
    .CHANNELS(2), .SAMPLE_BYTES(3), .CLK_DIV(CLK_DIV), .ADDR_WIDTH(11), .LFSR_SEED(32'h1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .direction(direction), .mode(mode),
    .pattern_word(pattern_word), .fifo_clk(fifo_clk), .fifo_data(fifo_data),
    .fifo_write(fifo_write), .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
    .sample_count(sample_count), .overflow_count(overflow_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  int          got_n, first_j, last_j, bad_cyc;
  logic [47:0] got_bytes;

  // Reference pattern state
  logic [23:0] m_ramp;
  logic [31:0] m_lfsr;
  int          m_frames, m_ovf, m_exp_n;
  logic [47:0] m_exp_bytes;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] pw;
    logic [10:0] ain, aout;
    logic        en, dir;
    int          nbytes;
    logic [47:0] bytes;   // byte k of the stream at [8k+:8]
    int          scnt, ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One frame-tick period, aligned so the capture and all 6 bytes fall inside it.
  task automatic run_window(input logic [1:0] m, input logic [23:0] pw,
                            input logic [10:0] ain, input logic [10:0] aout,
                            input logic en, input logic dir, input bit drop);
    mode = m; pattern_word = pw; fifo_addr_in = ain; fifo_addr_out = aout;
    enable = en; direction = dir;
    got_n = 0; got_bytes = '0; first_j = 0; last_j = 0; bad_cyc = 0;
    for (int j = 1; j <= int'(CLK_DIV); j++) begin
      @(negedge clk);
      if (busy !== fifo_write) bad_cyc++;
      if (fifo_write === 1'b1) begin
        if (got_n < 6) got_bytes[8*got_n +: 8] = fifo_data;
        if (got_n == 0) first_j = j;
        last_j = j;
        got_n++;
        if (drop) begin enable = 1'b0; direction = 1'b0; end
      end else if (fifo_data !== 8'h00) begin
        bad_cyc++;
      end
    end
  endtask

  task automatic check_window(input string name, input int exp_n, input logic [47:0] exp_b,
                              input int exp_scnt, input int exp_ovf);
    check({name, ".nbytes"}, 64'(got_n), 64'(exp_n));
    if (exp_n > 0) begin
      check({name, ".bytes"}, 64'(got_bytes), 64'(exp_b));
      check({name, ".start"}, 64'(first_j), 64'd10);
      check({name, ".contig"}, 64'(last_j - first_j + 1), 64'(got_n));
    end
    check({name, ".idle_busy"}, 64'(bad_cyc), 64'd0);
    check({name, ".sample_count"}, 64'(sample_count), 64'(exp_scnt));
    check({name, ".overflow_count"}, 64'(overflow_count), 64'(exp_ovf));
  endtask

  task automatic release_reset();
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic model_reset();
    m_ramp = '0; m_lfsr = 32'h1; m_frames = 0; m_ovf = 0;
  endtask

  task automatic model_frame(input logic [1:0] m, input logic [23:0] pw, input logic en,
                             input logic dir, input int used);
    logic [31:0] st;
    logic [23:0] s;
    m_exp_n = 0; m_exp_bytes = '0;
    if (!(en && dir)) return;
    if (2047 - used < 6) begin
      if (m_ovf < 65535) m_ovf++;
      return;
    end
    st = m_lfsr;
    for (int c = 0; c < 2; c++) begin
      case (m)
        2'd0:    s = pw;
        2'd1:    s = m_ramp + 24'(c);
        2'd2:    s = st[23:0];
        default: s = 24'((c << 16) | (m_frames % 65536));
      endcase
      st = lfsr_next(st);
      m_exp_bytes[24*c +: 24] = s;
    end
    m_exp_n = 6;
    if (m == 2'd1) m_ramp = m_ramp + 24'd1;
    if (m == 2'd2) m_lfsr = st;
    m_frames++;
  endtask

  vec_t vecs[12];

  initial begin
    int          used;
    logic [10:0] ain;
    logic [1:0]  m;
    logic [23:0] pw;
    logic        en, dir;

    vecs[0]  = '{2'd0, 24'h123456, 11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h123456_123456, 1, 0};
    vecs[1]  = '{2'd1, 24'h0,      11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h000001_000000, 2, 0};
    vecs[2]  = '{2'd1, 24'h0,      11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h000002_000001, 3, 0};
    vecs[3]  = '{2'd2, 24'h0,      11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h000003_000001, 4, 0};
    vecs[4]  = '{2'd2, 24'h0,      11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h00000D_000006, 5, 0};
    vecs[5]  = '{2'd0, 24'h123456, 11'h7F8, 11'h000, 1'b1, 1'b1, 6, 48'h123456_123456, 6, 0};
    vecs[6]  = '{2'd0, 24'h123456, 11'h7FA, 11'h000, 1'b1, 1'b1, 0, 48'h0,             6, 1};
    vecs[7]  = '{2'd0, 24'h123456, 11'h003, 11'h005, 1'b1, 1'b1, 0, 48'h0,             6, 2};
    vecs[8]  = '{2'd1, 24'h0,      11'h000, 11'h000, 1'b0, 1'b1, 0, 48'h0,             6, 2};
    vecs[9]  = '{2'd1, 24'h0,      11'h000, 11'h000, 1'b1, 1'b0, 0, 48'h0,             6, 2};
    vecs[10] = '{2'd2, 24'h0,      11'h000, 11'h000, 1'b0, 1'b0, 0, 48'h0,             6, 2};
    vecs[11] = '{2'd3, 24'h0,      11'h000, 11'h000, 1'b1, 1'b1, 6, 48'h010006_000006, 7, 2};

    repeat (3) @(negedge clk);
    check("reset.fifo_write", 64'(fifo_write), 64'd0);
    check("reset.fifo_data", 64'(fifo_data), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.sample_count", 64'(sample_count), 64'd0);
    check("reset.overflow_count", 64'(overflow_count), 64'd0);
    release_reset();

    foreach (vecs[i]) begin
      run_window(vecs[i].mode, vecs[i].pw, vecs[i].ain, vecs[i].aout, vecs[i].en, vecs[i].dir, 1'b0);
      check_window($sformatf("vec%0d", i), vecs[i].nbytes, vecs[i].bytes, vecs[i].scnt, vecs[i].ovf);
    end

    // Enable and direction dropped after the first byte: the frame still completes
    run_window(2'd0, 24'h123456, 11'h000, 11'h000, 1'b1, 1'b1, 1'b1);
    check_window("drop_en", 6, 48'h123456_123456, 8, 2);
    run_window(2'd0, 24'h123456, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0);
    check_window("after_drop", 0, 48'h0, 8, 2);

    // Reset on the third byte of a frame
    mode = 2'd1; enable = 1'b1; direction = 1'b1;
    got_n = 0;
    for (int j = 1; j <= int'(CLK_DIV) && got_n < 3; j++) begin
      @(negedge clk);
      if (fifo_write === 1'b1) got_n++;
    end
    check("midreset.third_byte_seen", 64'(got_n), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.fifo_write", 64'(fifo_write), 64'd0);
    check("midreset.fifo_data", 64'(fifo_data), 64'd0);
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.sample_count", 64'(sample_count), 64'd0);
    check("midreset.overflow_count", 64'(overflow_count), 64'd0);
    @(negedge clk);
    release_reset();
    model_reset();

    run_window(2'd1, 24'h0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0);
    model_frame(2'd1, 24'h0, 1'b1, 1'b1, 0);
    check_window("post_reset_ramp", 6, 48'h000001_000000, 1, 0);
    run_window(2'd2, 24'h0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0);
    model_frame(2'd2, 24'h0, 1'b1, 1'b1, 0);
    check_window("post_reset_lfsr", 6, 48'h000003_000001, 2, 0);

    for (int r = 0; r < 40; r++) begin
      m   = 2'($urandom_range(0, 3));
      pw  = 24'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      dir = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) used = 2039 + int'($urandom_range(0, 4));
      else                           used = int'($urandom_range(0, 2047));
      ain = 11'($urandom);
      run_window(m, pw, ain, ain - 11'(used), en, dir, 1'b0);
      model_frame(m, pw, en, dir, used);
      check_window($sformatf("rand%0d", r), m_exp_n, m_exp_bytes, m_frames, m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_adc_source.md
Name: pattern_adc_source

Overview:
Parametrised synthetic ADC data source for cosim and bring-up of slots with no real converter fitted. At a programmable sample rate it builds one frame of CHANNELS samples from a selectable pattern generator. It checks free space in the slot write FIFO from the FIFO pointers, then streams the frame into the FIFO one byte per clock. Frames that would overflow the FIFO are dropped and counted; write data is never corrupted.

Parameters:
CHANNELS, 2, samples per frame (1..8)
SAMPLE_BYTES, 3, bytes per sample (1..4); sample width SW = 8*SAMPLE_BYTES
CLK_DIV, 256, clk cycles per frame tick; must exceed CHANNELS*SAMPLE_BYTES
ADDR_WIDTH, 11, FIFO pointer width; FIFO depth 2^ADDR_WIDTH
LFSR_SEED, 32'h00000001, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  generator run enable
direction  in  1  slot direction; 1 = ADC (source active)
mode  in  2  0 constant, 1 ramp, 2 LFSR, 3 channel tag
pattern_word  in  SW  constant value for mode 0
fifo_clk  out  1  FIFO write clock, equal to clk
fifo_data  out  8  write byte
fifo_write  out  1  write strobe
fifo_addr_in  in  ADDR_WIDTH  FIFO write pointer
fifo_addr_out  in  ADDR_WIDTH  FIFO read pointer
sample_count  out  32  frames written, wraps
overflow_count  out  16  frames dropped, saturates at 16'hFFFF
busy  out  1  high while a frame is streaming

Behaviour:
- Reset: fifo_data=0, fifo_write=0, busy=0, counters=0, tick counter=0, ramp=0, lfsr=LFSR_SEED, state IDLE. Reset mid-frame aborts at once: fifo_write=0 on the cycle after reset is sampled.
- Tick counter runs 0..CLK_DIV-1 regardless of enable. A tick fires in the cycle the counter equals CLK_DIV-1, so the first tick comes on the CLK_DIV-th edge after reset is released.
- Space check: used = (fifo_addr_in - fifo_addr_out) mod 2^ADDR_WIDTH; free = 2^ADDR_WIDTH-1-used. N = CHANNELS*SAMPLE_BYTES.
- IDLE, tick with enable=1 and direction=1:
  - if free >= N: capture the frame into the shift register, go to SEND;
  - otherwise: overflow_count++ (saturating), stay in IDLE, pattern state not advanced.
- A tick with enable=0 or direction=0 is ignored.
- SEND: fifo_write=1 for exactly N consecutive cycles, starting the cycle after the capture edge.
  - Byte order: channel 0 first; within a sample, LSB byte first.
  - busy=1 for the same cycles.
  - After the last byte: fifo_write=0, fifo_data=0, sample_count++, back to IDLE.
- A tick during SEND (possible only if CLK_DIV is misconfigured) counts as an overflow.
- Deasserting enable or direction mid-frame does not truncate; the frame completes.
- fifo_data=0 whenever fifo_write=0.
- Patterns are evaluated at capture. Changes to mode and pattern_word apply from the next capture.
  - Mode 0: every channel = pattern_word.
  - Mode 1: channel c = (ramp + c) mod 2^SW; ramp increments by 1 per captured frame.
  - Mode 2: 32-bit Fibonacci LFSR, shift left, feedback = b31^b21^b1^b0 into bit 0. Channel c = low SW bits of the state after c steps. The register advances CHANNELS steps per captured frame.
  - Mode 3: channel c = {c[7:0], frame index low SW-8 bits}; when SW=8, just c.
  - Ramp and LFSR advance only in their own mode and only on captured (not dropped) frames.

Test Plan:
- CHANNELS=2, SAMPLE_BYTES=3, CLK_DIV=16, mode 0, pattern 24'h123456, empty FIFO; release reset -> tick on the 16th edge; fifo_write high 6 cycles with bytes 56 34 12 56 34 12; sample_count=1.
- Mode 1, same config, two ticks -> frame 1 bytes 00 00 00 01 00 00; frame 2 bytes 01 00 00 02 00 00.
- Mode 2, seed 1 -> frame 1 bytes 01 00 00 03 00 00; frame 2 bytes 06 00 00 0D 00 00.
- Near full: addr_in=0x7F8, addr_out=0x000 (free 7) -> frame written. addr_in=0x7FA (free 5) -> no fifo_write, overflow_count=1. Wrapped pointers addr_in=0x003, addr_out=0x005 (free 1) -> dropped, overflow_count=2.
- enable=0 or direction=0 across 3 ticks -> no writes, counters unchanged. Drop enable on the 2nd byte of a frame -> all 6 bytes still written, then none.
- Assert reset on the 3rd byte of a frame -> fifo_write=0 the next cycle, all counters 0. After release, the first frame starts from the reset pattern state.
